// File: rtl/icape2_model.sv
// Synthesizable model of the ICAPE2 configuration port. It covers sync detection,
// type-1/type-2 packet decode, and WBSTAR/CMD writes with IDCODE/WBSTAR/STAT readback.
module icape2_model #(
   parameter logic [31:0] DEVICE_ID         = 32'h0362_D093,
   parameter              ICAP_WIDTH        = "X32",
   parameter              SIM_CFG_FILE_NAME = "NONE"
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic        CSIB,
   input  logic        RDWRB,
   input  logic [31:0] I,
   output logic [31:0] O,
   output logic        synced,
   output logic [31:0] wbstar,
   output logic        iprog,
   output logic [4:0]  cmd
);

   localparam logic [31:0] SYNC_WORD   = 32'hAA99_5566;
   localparam logic [31:0] DUMMY_WORD  = 32'hFFFF_FFFF;
   localparam logic [4:0]  ADDR_CMD    = 5'h04;
   localparam logic [4:0]  ADDR_STAT   = 5'h07;
   localparam logic [4:0]  ADDR_IDCODE = 5'h0C;
   localparam logic [4:0]  ADDR_WBSTAR = 5'h10;
   localparam logic [4:0]  CMD_DESYNC  = 5'h0D;
   localparam logic [4:0]  CMD_IPROG   = 5'h0F;
   localparam logic [1:0]  OP_READ     = 2'b01;
   localparam logic [1:0]  OP_WRITE    = 2'b10;
   localparam logic [2:0]  HDR_TYPE1   = 3'b001;
   localparam logic [2:0]  HDR_TYPE2   = 3'b010;

   // Only the 32-bit port exists; other widths and the config file name change nothing.
   if (ICAP_WIDTH != "X32" || SIM_CFG_FILE_NAME != "NONE") begin : g_compat_only
   end

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_HDR    = 2'd1,
      ST_WDATA  = 2'd2,
      ST_RDATA  = 2'd3
   } state_t;

   function automatic logic [31:0] bit_swap(input logic [31:0] d);
      logic [31:0] r;
      r = 32'h0000_0000;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 8; j++) begin
            r[8*k+j] = d[8*k+7-j];
         end
      end
      return r;
   endfunction

   state_t      state_r,  state_s;
   logic        synced_r, synced_s;
   logic [31:0] wbstar_r, wbstar_s;
   logic [4:0]  cmd_r,    cmd_s;
   logic        iprog_r,  iprog_s;
   logic [31:0] o_r,      o_s;
   logic [4:0]  addr_r,   addr_s;
   logic [26:0] cnt_r,    cnt_s;

   logic [31:0] word_s;
   logic        wr_s;
   logic        rd_s;
   logic        hdr_valid_s;
   logic [1:0]  hdr_op_s;
   logic [26:0] hdr_cnt_s;
   logic [4:0]  hdr_addr_s;
   logic [31:0] rd_val_s;

   assign word_s = bit_swap(I);
   assign wr_s   = !CSIB && !RDWRB;
   assign rd_s   = !CSIB && RDWRB;

   // Header field decode; dummy and sync words never count as headers.
   always_comb begin
      hdr_valid_s = 1'b0;
      hdr_op_s    = 2'b00;
      hdr_cnt_s   = 27'd0;
      hdr_addr_s  = addr_r;
      if (word_s == DUMMY_WORD || word_s == SYNC_WORD) begin
         hdr_valid_s = 1'b0;
      end else if (word_s[31:29] == HDR_TYPE1) begin
         hdr_valid_s = 1'b1;
         hdr_op_s    = word_s[28:27];
         hdr_cnt_s   = {16'd0, word_s[10:0]};
         hdr_addr_s  = word_s[17:13];
      end else if (word_s[31:29] == HDR_TYPE2) begin
         hdr_valid_s = 1'b1;
         hdr_op_s    = word_s[28:27];
         hdr_cnt_s   = word_s[26:0];
      end else begin
         hdr_valid_s = 1'b0;
      end
   end

   // Readback multiplexer for the addressed register.
   always_comb begin
      case (addr_r)
         ADDR_IDCODE: rd_val_s = DEVICE_ID;
         ADDR_WBSTAR: rd_val_s = wbstar_r;
         ADDR_STAT:   rd_val_s = {27'd0, synced_r, 4'd0};
         default:     rd_val_s = 32'h0000_0000;
      endcase
   end

   // Next-state and next-register computation for one port cycle.
   always_comb begin
      state_s  = state_r;
      synced_s = synced_r;
      wbstar_s = wbstar_r;
      cmd_s    = cmd_r;
      iprog_s  = 1'b0;
      o_s      = o_r;
      addr_s   = addr_r;
      cnt_s    = cnt_r;
      if (wr_s) begin
         case (state_r)
            ST_UNSYNC: begin
               o_s = DUMMY_WORD;
               if (word_s == SYNC_WORD) begin
                  state_s  = ST_HDR;
                  synced_s = 1'b1;
               end else begin
                  state_s = ST_UNSYNC;
               end
            end
            ST_HDR: begin
               o_s = DUMMY_WORD;
               if (hdr_valid_s) begin
                  addr_s = hdr_addr_s;
                  if (hdr_cnt_s != 27'd0 && hdr_op_s == OP_WRITE) begin
                     state_s = ST_WDATA;
                     cnt_s   = hdr_cnt_s;
                  end else if (hdr_cnt_s != 27'd0 && hdr_op_s == OP_READ) begin
                     state_s = ST_RDATA;
                     cnt_s   = hdr_cnt_s;
                  end else begin
                     state_s = ST_HDR;
                  end
               end else begin
                  state_s = ST_HDR;
               end
            end
            ST_WDATA: begin
               o_s   = DUMMY_WORD;
               cnt_s = cnt_r - 27'd1;
               if (cnt_r == 27'd1) begin
                  state_s = ST_HDR;
               end else begin
                  state_s = ST_WDATA;
               end
               case (addr_r)
                  ADDR_WBSTAR: wbstar_s = word_s;
                  ADDR_CMD: begin
                     cmd_s = word_s[4:0];
                     case (word_s[4:0])
                        CMD_IPROG: begin
                           iprog_s  = 1'b1;
                           synced_s = 1'b0;
                           state_s  = ST_UNSYNC;
                           cnt_s    = 27'd0;
                        end
                        CMD_DESYNC: begin
                           synced_s = 1'b0;
                           state_s  = ST_UNSYNC;
                           cnt_s    = 27'd0;
                        end
                        default: cmd_s = word_s[4:0];
                     endcase
                  end
                  default: wbstar_s = wbstar_r;
               endcase
            end
            default: state_s = state_r;
         endcase
      end else if (rd_s) begin
         case (state_r)
            ST_RDATA: begin
               o_s   = bit_swap(rd_val_s);
               cnt_s = cnt_r - 27'd1;
               if (cnt_r == 27'd1) begin
                  state_s = ST_HDR;
               end else begin
                  state_s = ST_RDATA;
               end
            end
            ST_WDATA: o_s = o_r;
            default:  o_s = DUMMY_WORD;
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and output registers; reset also drops any packet in flight.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_UNSYNC;
         synced_r <= 1'b0;
         wbstar_r <= 32'h0000_0000;
         cmd_r    <= 5'd0;
         iprog_r  <= 1'b0;
         o_r      <= 32'hFFFF_FFFF;
         addr_r   <= 5'd0;
         cnt_r    <= 27'd0;
      end else begin
         state_r  <= state_s;
         synced_r <= synced_s;
         wbstar_r <= wbstar_s;
         cmd_r    <= cmd_s;
         iprog_r  <= iprog_s;
         o_r      <= o_s;
         addr_r   <= addr_s;
         cnt_r    <= cnt_s;
      end
   end

   assign O      = o_r;
   assign synced = synced_r;
   assign wbstar = wbstar_r;
   assign iprog  = iprog_r;
   assign cmd    = cmd_r;

endmodule

// File: tb/tb_icape2_model.sv
// Randomized self-checking bench for icape2_model against a packet-level reference model.
module tb_icape2_model;

   logic        sclk;
   logic        rst_n;
   logic        CSIB;
   logic        RDWRB;
   logic [31:0] I;
   logic [31:0] O;
   logic        synced;
   logic [31:0] wbstar;
   logic        iprog;
   logic [4:0]  cmd;

   int n_cmp;
   int n_err;

   // reference model state
   bit          m_synced;
   logic [31:0] m_wbstar;
   logic [31:0] m_o;
   logic [4:0]  m_cmd;
   logic [4:0]  m_addr;
   bit          m_iprog;
   int unsigned m_wleft;
   int unsigned m_rleft;

   icape2_model dut (
      .sclk   (sclk),
      .rst_n  (rst_n),
      .CSIB   (CSIB),
      .RDWRB  (RDWRB),
      .I      (I),
      .O      (O),
      .synced (synced),
      .wbstar (wbstar),
      .iprog  (iprog),
      .cmd    (cmd)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   function automatic logic [31:0] swz(input logic [31:0] w);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 32; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
      return r;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check_val("O",      O,              m_o);
      check_val("synced", {31'd0, synced}, {31'd0, m_synced});
      check_val("wbstar", wbstar,         m_wbstar);
      check_val("iprog",  {31'd0, iprog},  {31'd0, m_iprog});
      check_val("cmd",    {27'd0, cmd},    {27'd0, m_cmd});
   endtask

   task automatic model_reset();
      m_synced = 1'b0;
      m_wbstar = 32'h0;
      m_o      = 32'hFFFF_FFFF;
      m_cmd    = 5'd0;
      m_addr   = 5'd0;
      m_iprog  = 1'b0;
      m_wleft  = 0;
      m_rleft  = 0;
   endtask

   task automatic model_write(input logic [31:0] w);
      int unsigned n;
      logic [1:0]  op;
      if (!m_synced) begin
         m_o = 32'hFFFF_FFFF;
         if (w == 32'hAA99_5566) m_synced = 1'b1;
      end else if (m_wleft > 0) begin
         m_o = 32'hFFFF_FFFF;
         m_wleft = m_wleft - 1;
         if (m_addr == 5'h10) m_wbstar = w;
         else if (m_addr == 5'h04) begin
            m_cmd = w[4:0];
            if (w[4:0] == 5'h0F) begin
               m_iprog = 1'b1; m_synced = 1'b0; m_wleft = 0;
            end else if (w[4:0] == 5'h0D) begin
               m_synced = 1'b0; m_wleft = 0;
            end
         end
      end else if (m_rleft > 0) begin
         m_o = m_o;
      end else begin
         m_o = 32'hFFFF_FFFF;
         op = 2'b00;
         n = 0;
         if (w != 32'hFFFF_FFFF && w != 32'hAA99_5566) begin
            if (w[31:29] == 3'd1) begin
               m_addr = w[17:13]; op = w[28:27]; n = w[10:0];
            end else if (w[31:29] == 3'd2) begin
               op = w[28:27]; n = w[26:0];
            end
         end
         if (op == 2'b10) m_wleft = n;
         else if (op == 2'b01) m_rleft = n;
      end
   endtask

   task automatic model_read();
      logic [31:0] v;
      if (m_wleft > 0) begin
         m_o = m_o;
      end else if (m_rleft > 0) begin
         if (m_addr == 5'h0C)      v = 32'h0362_D093;
         else if (m_addr == 5'h10) v = m_wbstar;
         else if (m_addr == 5'h07) v = m_synced ? 32'h0000_0010 : 32'h0;
         else                      v = 32'h0;
         m_o = swz(v);
         m_rleft = m_rleft - 1;
      end else begin
         m_o = 32'hFFFF_FFFF;
      end
   endtask

   task automatic drive(input bit csib, input bit rdwrb, input logic [31:0] w);
      @(negedge sclk);
      CSIB  = csib;
      RDWRB = rdwrb;
      I     = swz(w);
      @(posedge sclk);
      m_iprog = 1'b0;
      if (!csib && !rdwrb)     model_write(w);
      else if (!csib && rdwrb) model_read();
      #1;
      check_all();
   endtask

   task automatic wr(input logic [31:0] w);
      drive(1'b0, 1'b0, w);
   endtask

   task automatic do_reset();
      @(negedge sclk);
      rst_n = 1'b0;
      CSIB  = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge sclk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] gen_word();
      logic [4:0] addrs [5];
      logic [4:0] a;
      logic [1:0] op;
      logic [4:0] c;
      int r;
      addrs[0] = 5'h04; addrs[1] = 5'h07; addrs[2] = 5'h0C; addrs[3] = 5'h10;
      addrs[4] = 5'($urandom);
      a  = addrs[$urandom_range(0, 4)];
      op = 2'($urandom);
      r  = $urandom_range(0, 9);
      case (r)
         0: return 32'hAA99_5566;
         1: return 32'hFFFF_FFFF;
         2, 3, 4: return {3'b001, op, 9'($urandom), a, 2'($urandom), 11'($urandom_range(0, 3))};
         5: return {3'b010, op, 27'($urandom_range(0, 3))};
         6: begin
            c = ($urandom_range(0, 2) == 0) ? 5'h0F : (($urandom_range(0, 1) == 0) ? 5'h0D : 5'($urandom));
            return {27'($urandom), c};
         end
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int k;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      CSIB  = 1'b1;
      RDWRB = 1'b0;
      I     = 32'h0;
      model_reset();
      #12;
      check_all();
      @(negedge sclk);
      rst_n = 1'b1;

      // IPROG sequence with WBSTAR load
      wr(32'hFFFF_FFFF); wr(32'hAA99_5566); wr(32'h2000_0000); wr(32'h3002_0001);
      wr(32'h0007_D000); wr(32'h3000_8001); wr(32'h0000_000F);
      check_val("iprog_pulse", {31'd0, iprog}, 32'd1);
      check_val("iprog_wbstar", wbstar, 32'h0007_D000);
      check_val("iprog_cmd", {27'd0, cmd}, 32'h0000_000F);
      wr(32'h2000_0000);
      check_val("iprog_clear", {31'd0, iprog}, 32'd0);
      check_val("iprog_desync", {31'd0, synced}, 32'd0);

      // writes without sync are ignored
      do_reset();
      wr(32'h3002_0001); wr(32'h1234_5678);
      check_val("nosync_wbstar", wbstar, 32'h0);
      check_val("nosync_synced", {31'd0, synced}, 32'd0);

      // IDCODE readback
      wr(32'hAA99_5566); wr(32'h2801_8001);
      drive(1'b0, 1'b1, 32'h0);
      check_val("idcode_read", O, 32'hC046_0BC9);
      drive(1'b0, 1'b1, 32'h0);
      check_val("idcode_after", O, 32'hFFFF_FFFF);

      // CSIB high in the middle of a packet
      wr(32'h3002_0001);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, $urandom);
      wr(32'hABCD_0000);
      check_val("csib_hold_wbstar", wbstar, 32'hABCD_0000);

      // reset between header and data
      do_reset();
      wr(32'hAA99_5566); wr(32'h3002_0001);
      do_reset();
      wr(32'h0007_D000);
      check_val("rst_mid_wbstar", wbstar, 32'h0);
      check_val("rst_mid_synced", {31'd0, synced}, 32'd0);

      // DESYNC command
      wr(32'hAA99_5566); wr(32'h3000_8001); wr(32'h0000_000D);
      check_val("desync_synced", {31'd0, synced}, 32'd0);
      check_val("desync_iprog", {31'd0, iprog}, 32'd0);
      check_val("desync_cmd", {27'd0, cmd}, 32'h0000_000D);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         k = $urandom_range(0, 99);
         if (k == 0)      do_reset();
         else if (k < 60) wr(gen_word());
         else if (k < 88) drive(1'b0, 1'b1, $urandom);
         else             drive(1'b1, 1'($urandom), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
